game_key_conditioner: RTL and testbench

//   Front end for the 24-points game core. Synchronises and debounces the four card keys
//   (k1..k4) and the four operator keys, then turns each clean press into a one-cycle token.

---
 rtl/game_key_conditioner.sv | 151 +++++++++++++++
 tb/tb_game_key_conditioner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_key_conditioner.sv
// Key front end for the 24-points game: synchronise and debounce eight keys, then
// turn clean presses into tokens in the order card,op,card,op,card,op,card.
module game_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       k1,
  input  logic       k2,
  input  logic       k3,
  input  logic       k4,
  input  logic       plus,
  input  logic       minus,
  input  logic       multiply,
  input  logic       divide,
  output logic       tok_valid,
  output logic [3:0] tok_code,
  output logic [3:0] cards_used,
  output logic [2:0] step,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    EXP_CARD = 2'd0,
    EXP_OP   = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit position equals the token code.
  logic [7:0] raw;
  assign raw = {divide, multiply, minus, plus, k4, k3, k2, k1};

  logic [7:0]            key_p0, key_p1, deb_p2, deb_p3;
  logic [7:0][CNT_W-1:0] cnt;
  logic [7:0]            press;
  logic                  multi;
  logic [2:0]            idx;
  logic                  is_card;

  state_t     state, state_n;
  logic [2:0] step_n;
  logic [3:0] used_n, code_n;
  logic       tv_n, err_n;

  // Stage p0/p1: synchroniser; p2: debounced level; p3: previous level for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_p0 <= '0;
      key_p1 <= '0;
      deb_p2 <= '0;
      deb_p3 <= '0;
      cnt    <= '0;
    end else begin
      key_p0 <= raw;
      key_p1 <= key_p0;
      deb_p3 <= deb_p2;
      for (int i = 0; i < 8; i++) begin
        if (key_p1[i] == deb_p2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          deb_p2[i] <= ~deb_p2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign press   = deb_p2 & ~deb_p3;
  assign multi   = |(press & (press - 8'd1));
  assign is_card = ~idx[2];

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (press[i]) idx = 3'(i);
    end
  end

  // Entry-order FSM: a rejected press only pulses err
  always_comb begin
    state_n = state;
    step_n  = step;
    used_n  = cards_used;
    code_n  = tok_code;
    tv_n    = 1'b0;
    err_n   = 1'b0;
    if (clear) begin
      state_n = EXP_CARD;
      step_n  = '0;
      used_n  = '0;
    end else if (|press && state != DONE) begin
      if (multi) begin
        err_n = 1'b1;
      end else begin
        case (state)
          EXP_CARD: begin
            if (is_card && !cards_used[idx[1:0]]) begin
              used_n[idx[1:0]] = 1'b1;
              step_n           = step + 3'd1;
              tv_n             = 1'b1;
              code_n           = {1'b0, idx};
              state_n          = (step == 3'd6) ? DONE : EXP_OP;
            end else begin
              err_n = 1'b1;
            end
          end
          EXP_OP: begin
            if (!is_card) begin
              step_n  = step + 3'd1;
              tv_n    = 1'b1;
              code_n  = {1'b0, idx};
              state_n = EXP_CARD;
            end else begin
              err_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= EXP_CARD;
      step       <= '0;
      cards_used <= '0;
      tok_valid  <= 1'b0;
      tok_code   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      cards_used <= used_n;
      tok_valid  <= tv_n;
      tok_code   <= code_n;
      err        <= err_n;
    end
  end

  assign done = (step == 3'd7);

endmodule

// File: tb/tb_game_key_conditioner.sv
// Bench for game_key_conditioner with a 4-cycle debounce: scenario table, hand-written
// corner sequences and random stimulus checked every cycle against a reference model.
module tb_game_key_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] keys = '0;
  logic       tok_valid, done, err;
  logic [3:0] tok_code, cards_used;
  logic [2:0] step;

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 1'b0;

  game_key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock(clk), .reset(rst_n), .clear(clear),
    .k1(keys[0]), .k2(keys[1]), .k3(keys[2]), .k4(keys[3]),
    .plus(keys[4]), .minus(keys[5]), .multiply(keys[6]), .divide(keys[7]),
    .tok_valid(tok_valid), .tok_code(tok_code), .cards_used(cards_used),
    .step(step), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: keys[] sampled at each edge form a history; a key's accepted
  // level changes once the last D synchronised samples all disagree with it.
  bit [7:0] mh [0:D];
  bit [7:0] mlvl, mpend;
  bit       m_tv, m_err;
  bit [3:0] m_code, m_used;
  int       m_step;

  task automatic model_reset();
    for (int j = 0; j <= D; j++) mh[j] = '0;
    mlvl = '0; mpend = '0; m_tv = 0; m_err = 0;
    m_code = '0; m_used = '0; m_step = 0;
  endtask

  task automatic model_edge();
    bit [7:0] newp;
    int kk;
    bit card, flip;
    m_tv = 0;
    m_err = 0;
    if (clear) begin
      m_step = 0;
      m_used = '0;
    end else if (m_step < 7 && mpend != 0) begin
      if ($countones(mpend) > 1) m_err = 1;
      else begin
        kk = 0;
        for (int k = 0; k < 8; k++) if (mpend[k]) kk = k;
        card = (kk < 4);
        if (card == (m_step % 2 == 0) && !(card && m_used[kk[1:0]])) begin
          m_tv = 1;
          m_code = 4'(kk);
          if (card) m_used[kk[1:0]] = 1'b1;
          m_step++;
        end else m_err = 1;
      end
    end
    newp = '0;
    for (int k = 0; k < 8; k++) begin
      flip = 1;
      for (int j = 1; j <= D; j++) if (mh[j][k] == mlvl[k]) flip = 0;
      if (flip) begin
        if (!mlvl[k]) newp[k] = 1'b1;
        mlvl[k] = ~mlvl[k];
      end
    end
    mpend = newp;
    for (int j = D; j >= 1; j--) mh[j] = mh[j-1];
    mh[0] = keys;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_edge();
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model", int'({tok_valid, tok_code, cards_used, step, done, err}),
            int'({m_tv, m_code, m_used, 3'(m_step), (m_step == 7), m_err}));
  end

  task automatic tick(inout int ntv, inout int nerr);
    @(negedge clk);
    if (tok_valid) ntv++;
    if (err) nerr++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    int a = 0, b = 0;
    repeat (n) tick(a, b);
  endtask

  task automatic do_reset();
    keys = '0;
    clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_tok(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (tok_valid) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    bit       rst;
    int       key;
    int       exp_tok;
    int       exp_err;
    bit [3:0] exp_code;
    bit [2:0] exp_step;
    bit [3:0] exp_cu;
  } vec_t;

  vec_t tbl[12];

  task automatic apply_row(input vec_t v, input int i);
    int ntv = 0, nerr = 0;
    if (v.rst) begin
      do_reset();
      return;
    end
    keys[v.key] = 1'b1;
    repeat (10) tick(ntv, nerr);
    keys[v.key] = 1'b0;
    repeat (10) tick(ntv, nerr);
    check($sformatf("row%0d_tok", i), ntv, v.exp_tok);
    check($sformatf("row%0d_err", i), nerr, v.exp_err);
    check($sformatf("row%0d_code", i), tok_code, v.exp_code);
    check($sformatf("row%0d_step", i), step, v.exp_step);
    check($sformatf("row%0d_cards", i), cards_used, v.exp_cu);
    check($sformatf("row%0d_done", i), done, (v.exp_step == 3'd7));
  endtask

  initial begin
    int lat, ntv, nerr, hold, r;
    // legal round k4,+,k2,+,k1,*,k3
    tbl[0]  = '{0, 3, 1, 0, 4'd3, 3'd1, 4'h8};
    tbl[1]  = '{0, 4, 1, 0, 4'd4, 3'd2, 4'h8};
    tbl[2]  = '{0, 1, 1, 0, 4'd1, 3'd3, 4'hA};
    tbl[3]  = '{0, 4, 1, 0, 4'd4, 3'd4, 4'hA};
    tbl[4]  = '{0, 0, 1, 0, 4'd0, 3'd5, 4'hB};
    tbl[5]  = '{0, 6, 1, 0, 4'd6, 3'd6, 4'hB};
    tbl[6]  = '{0, 2, 1, 0, 4'd2, 3'd7, 4'hF};
    // order violations: card after card, reused card
    tbl[7]  = '{1, 0, 0, 0, 4'd0, 3'd0, 4'h0};
    tbl[8]  = '{0, 3, 1, 0, 4'd3, 3'd1, 4'h8};
    tbl[9]  = '{0, 2, 0, 1, 4'd3, 3'd1, 4'h8};
    tbl[10] = '{0, 4, 1, 0, 4'd4, 3'd2, 4'h8};
    tbl[11] = '{0, 3, 0, 1, 4'd4, 3'd2, 4'h8};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_outputs", int'({tok_valid, tok_code, cards_used, step, done, err}), 0);
    rst_n = 1'b1;

    // exact press latency
    keys[3] = 1'b1;
    wait_tok(lat);
    check("k4_latency", lat, 7);
    check("k4_code", tok_code, 3);
    check("k4_step", step, 1);
    check("k4_cards", cards_used, 4'b1000);
    keys = '0;
    idle(10);

    do_reset();
    for (int i = 0; i < 12; i++) apply_row(tbl[i], i);

    // short glitch on an operator while an operator is expected
    do_reset();
    apply_row(tbl[0], 100);
    ntv = 0; nerr = 0;
    keys[4] = 1'b1;
    repeat (3) tick(ntv, nerr);
    keys[4] = 1'b0;
    repeat (15) tick(ntv, nerr);
    check("glitch_tok", ntv, 0);
    check("glitch_err", nerr, 0);
    check("glitch_step", step, 1);

    // two cards in the same cycle
    do_reset();
    ntv = 0; nerr = 0;
    keys[1:0] = 2'b11;
    repeat (10) tick(ntv, nerr);
    keys = '0;
    repeat (10) tick(ntv, nerr);
    check("simul_tok", ntv, 0);
    check("simul_err", nerr, 1);
    check("simul_step", step, 0);

    // reset while k1 is mid-debounce
    do_reset();
    keys[0] = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", int'({tok_valid, tok_code, cards_used, step, done, err}), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_tok(lat);
    check("midreset_latency", lat, 7);
    check("midreset_step", step, 1);
    keys = '0;
    idle(10);

    // clear after a finished round while k3 stays held
    do_reset();
    for (int i = 0; i < 6; i++) apply_row(tbl[i], 200 + i);
    ntv = 0; nerr = 0;
    keys[2] = 1'b1;
    repeat (10) tick(ntv, nerr);
    check("round_done", done, 1);
    check("round_cards", cards_used, 4'hF);
    clear = 1'b1;
    ntv = 0;
    tick(ntv, nerr);
    clear = 1'b0;
    check("clear_step", step, 0);
    check("clear_done", done, 0);
    check("clear_cards", cards_used, 0);
    repeat (15) tick(ntv, nerr);
    check("clear_noreport", ntv, 0);
    keys = '0;
    idle(10);

    // random traffic against the model
    repeat (300) begin
      r = int'($urandom % 16);
      if (r == 0) begin
        keys = '0;
        keys[$urandom % 8] = 1'b1;
        keys[$urandom % 8] = 1'b1;
      end else if (r < 9) begin
        keys = 8'(1 << ($urandom % 8));
      end else begin
        keys = '0;
      end
      if (m_step == 7 && $urandom % 3 == 0) clear = 1'b1;
      else if ($urandom % 25 == 0) clear = 1'b1;
      if ($urandom % 40 == 0) begin
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end
      hold = int'($urandom_range(1, 12));
      idle(1);
      clear = 1'b0;
      idle(hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
